// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO between the write-through D-cache and data memory,
// with store-to-load forwarding. Define WB_COALESCE_EN to merge stores to an already-pending word.
module store_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wrValid,
  input  logic [ADDR_WIDTH-1:0] wrAddress,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  wrReady,
  input  logic [ADDR_WIDTH-1:0] lookupAddress,
  output logic                  lookupHit,
  output logic [DATA_WIDTH-1:0] lookupData,
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic                  memAck,
  output logic                  bufferEmpty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic [WA_W-1:0]       entry_addr_q [DEPTH];
  logic [WA_W-1:0]       entry_addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [WA_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  logic [WA_W-1:0]  wr_word, lk_word;
  logic [PTR_W-1:0] l_idx;
  logic             coal_hit, push, pop;
  logic             unused_low_bits;

  assign wr_word         = wrAddress[ADDR_WIDTH-1:2];
  assign lk_word         = lookupAddress[ADDR_WIDTH-1:2];
  assign unused_low_bits = ^{wrAddress[1:0], lookupAddress[1:0]};

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] coal_idx;
  logic [PTR_W-1:0] c_idx;

  // The head is skipped: it is either in flight or being latched for launch this edge.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = head_q;
    c_idx    = head_q;
    for (int i = 1; i < DEPTH; i++) begin
      c_idx = head_q + PTR_W'(i);
      if (valid_q[c_idx] && (entry_addr_q[c_idx] == wr_word)) begin
        coal_hit = 1'b1;
        coal_idx = c_idx;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  assign wrReady = (count_q != FULL) || coal_hit;
  assign push    = wrValid && wrReady && !coal_hit;
  assign pop     = (state_q == S_REQ) && memAck;

  always_comb begin
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;
    valid_d      = valid_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    if (push) begin
      entry_addr_d[tail_q] = wr_word;
      entry_data_d[tail_q] = wrData;
      valid_d[tail_q]      = 1'b1;
      tail_d               = tail_q + PTR_W'(1);
    end
`ifdef WB_COALESCE_EN
    if (wrValid && coal_hit) begin
      entry_data_d[coal_idx] = wrData;
    end
`endif
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Drain FSM: IDLE always spends a cycle before REQ, which leaves a gap between writes.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = entry_addr_q[head_q];
          mem_data_d = entry_data_q[head_q];
        end
      end
      S_REQ: begin
        if (memAck) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_ff @(posedge clock) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    l_idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      l_idx = head_q + PTR_W'(i);
      if (valid_q[l_idx] && (entry_addr_q[l_idx] == lk_word)) begin
        lookupHit  = 1'b1;
        lookupData = entry_data_q[l_idx];
      end
    end
  end

  assign memReq       = mem_req_q;
  assign memAddress   = {mem_addr_q, 2'b00};
  assign memWriteData = mem_data_q;
  assign bufferEmpty  = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_store_write_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wrValid;
  logic [31:0] wrAddress, wrData, lookupAddress;
  logic        wrReady, lookupHit, memReq, memAck, bufferEmpty;
  logic [31:0] lookupData, memAddress, memWriteData;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .wrValid(wrValid), .wrAddress(wrAddress), .wrData(wrData), .wrReady(wrReady),
    .lookupAddress(lookupAddress), .lookupHit(lookupHit), .lookupData(lookupData),
    .memReq(memReq), .memAddress(memAddress), .memWriteData(memWriteData),
    .memAck(memAck), .bufferEmpty(bufferEmpty)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: pending stores oldest-first, plus whether the head is currently requested.
  logic [31:0] q_a[$];
  logic [31:0] q_d[$];
  bit          busy;
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int find_young(input logic [31:0] a, input int start);
    int r = -1;
    for (int k = start; k < q_a.size(); k++)
      if (q_a[k][31:2] == a[31:2]) r = k;
    return r;
  endfunction

  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input bit ack, input logic [31:0] la);
    int ci, li;
    bit exp_ready, push, pop, launch;
    @(negedge clock);
    wrValid = v; wrAddress = a; wrData = d; memAck = ack; lookupAddress = la;
    #1;
    ci = -1;
`ifdef WB_COALESCE_EN
    ci = find_young(a, 1);
`endif
    exp_ready = (q_a.size() < DEPTH) || (ci >= 0);
    li = find_young(la, 0);
    chk("wrReady", 32'(wrReady), 32'(exp_ready));
    chk("lookupHit", 32'(lookupHit), 32'(li >= 0));
    chk("lookupData", lookupData, (li >= 0) ? q_d[li] : 32'h0);
    chk("bufferEmpty", 32'(bufferEmpty), 32'((q_a.size() == 0) && !busy));
    chk("memReq", 32'(memReq), 32'(busy));
    if (busy) begin
      chk("memAddress", memAddress, {q_a[0][31:2], 2'b00});
      chk("memWriteData", memWriteData, q_d[0]);
    end
    if (memReq && ack) begin
      obs_a.push_back(memAddress);
      obs_d.push_back(memWriteData);
    end
    pop    = busy && ack;
    launch = !busy && (q_a.size() > 0);
    push   = v && exp_ready && (ci < 0);
    if (v && ci >= 0) q_d[ci] = d;
    if (pop) begin
      void'(q_a.pop_front());
      void'(q_d.pop_front());
    end
    if (push) begin
      q_a.push_back(a);
      q_d.push_back(d);
    end
    if (launch) busy = 1'b1;
    else if (pop) busy = 1'b0;
    @(posedge clock);
  endtask

  task automatic idle(input int n, input bit ack);
    for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 32'h0, ack, 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (q_a.size() != 0 || busy); k++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    idle(1, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear with no clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_memReq", 32'(memReq), 32'h0);
    chk("rst_bufferEmpty", 32'(bufferEmpty), 32'h1);
    chk("rst_wrReady", 32'(wrReady), 32'h1);
    chk("rst_lookupHit", 32'(lookupHit), 32'h0);
    chk("rst_lookupData", lookupData, 32'h0);
    chk("rst_memAddress", memAddress, 32'h0);
    chk("rst_memWriteData", memWriteData, 32'h0);
    q_a.delete();
    q_d.delete();
    busy = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [31:0] ra, rl;
    wrValid = 1'b0; wrAddress = '0; wrData = '0; memAck = 1'b0; lookupAddress = '0;
    reset_n = 1'b1;
    #2;
    do_reset();

    // Single store: request one cycle after acceptance, stable while unacked.
    base = obs_a.size();
    cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h10);
    idle(4, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    idle(1, 1'b0);
    chk("single_writes", 32'(obs_a.size() - base), 32'd1);
    chk("single_addr", obs_a[base], 32'h0000_0010);
    chk("single_data", obs_d[base], 32'hDEAD_BEEF);

    // Five back-to-back stores into a 4-deep buffer; the fifth waits for a pop.
    base = obs_a.size();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h100 + 32'(i) * 4, 32'hA000 + 32'(i), 1'b0, 32'h108);
    cycle(1'b1, 32'h110, 32'hA004, 1'b0, 32'h0);
    cycle(1'b1, 32'h110, 32'hA004, 1'b1, 32'h0);
    cycle(1'b1, 32'h110, 32'hA004, 1'b0, 32'h110);
    drain();
    chk("fifo_writes", 32'(obs_a.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < obs_a.size()) begin
        chk("fifo_order_addr", obs_a[base + k], 32'h100 + 32'(k) * 4);
        chk("fifo_order_data", obs_d[base + k], 32'hA000 + 32'(k));
      end
    end

    // Forwarding: youngest duplicate wins, neighbouring word misses.
    cycle(1'b1, 32'h20, 32'h1111, 1'b0, 32'h0);
    cycle(1'b1, 32'h20, 32'h2222, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h23);
    chk("fwd_hit", 32'(lookupHit), 32'h1);
    chk("fwd_data", lookupData, 32'h2222);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h24);
    chk("fwd_miss_data", lookupData, 32'h0);
    drain();

    // Reset while a request is outstanding, with memAck arriving around and after it.
    base = obs_a.size();
    cycle(1'b1, 32'h30, 32'h55, 1'b0, 32'h0);
    cycle(1'b1, 32'h38, 32'h66, 1'b0, 32'h0);
    idle(1, 1'b0);
    @(negedge clock);
    memAck = 1'b1;
    #2;
    do_reset();
    idle(2, 1'b1);
    cycle(1'b1, 32'h34, 32'h77, 1'b0, 32'h34);
    drain();
    chk("post_rst_writes", 32'(obs_a.size() - base), 32'd1);
    if (obs_a.size() > base) begin
      chk("post_rst_addr", obs_a[base], 32'h34);
      chk("post_rst_data", obs_d[base], 32'h77);
    end

    // Coalescing scenario: same word twice behind a different head.
    base = obs_a.size();
    cycle(1'b1, 32'h40, 32'h0000_000A, 1'b0, 32'h0);
    cycle(1'b1, 32'h44, 32'h0000_000B, 1'b0, 32'h0);
    cycle(1'b1, 32'h44, 32'h0000_000C, 1'b0, 32'h44);
    drain();
`ifdef WB_COALESCE_EN
    chk("coal_writes", 32'(obs_a.size() - base), 32'd2);
`else
    chk("coal_writes", 32'(obs_a.size() - base), 32'd3);
`endif
    if (obs_a.size() > base) begin
      chk("coal_last_addr", obs_a[obs_a.size() - 1], 32'h44);
      chk("coal_last_data", obs_d[obs_d.size() - 1], 32'h0000_000C);
    end

    // Random traffic over a small address window to provoke duplicates and stalls.
    for (int n = 0; n < 400; n++) begin
      ra = 32'h200 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      rl = 32'h200 + 32'($urandom_range(0, 8)) * 4 + 32'($urandom_range(0, 3));
      cycle(1'($urandom % 2), ra, $urandom, ($urandom % 3) == 0, rl);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write FIFO directly downstream of the data cache in the memory stage.
- Accepts word stores from the write-through data cache in a single cycle, then drains them one at a time to the backing data memory over a req/ack handshake.
- Provides a combinational store-to-load forwarding lookup, so cache reads see pending stores.
- Exposes an empty flag, used for fences and halt.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of two, 2..16.
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, store word width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- wrValid  in  1  cache presents a store this cycle.
- wrAddress  in  ADDR_WIDTH  store address; bits [1:0] ignored (word-aligned).
- wrData  in  DATA_WIDTH  store data.
- wrReady  out  1  buffer can accept a store; a store is taken when wrValid && wrReady at posedge.
- lookupAddress  in  ADDR_WIDTH  load address from cache, for forwarding.
- lookupHit  out  1  some valid entry matches lookupAddress[ADDR_WIDTH-1:2].
- lookupData  out  DATA_WIDTH  data of the youngest matching entry; 0 when no hit.
- memReq  out  1  write request to data memory.
- memAddress  out  ADDR_WIDTH  head entry address, low two bits forced to 0.
- memWriteData  out  DATA_WIDTH  head entry data.
- memAck  in  1  memory completed the write; sampled at posedge only while memReq=1.
- bufferEmpty  out  1  count==0 and no request in flight.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset clears all of the following:
  - count, head and tail pointers, and the entry valid bits.
  - Drain FSM returns to IDLE.
  - memReq=0, memAddress=0, memWriteData=0.
  - Reset outputs: wrReady=1, bufferEmpty=1, lookupHit=0, lookupData=0.
- Reset mid-transaction drops the in-flight write; memAck arriving after reset is ignored.
- Storage: circular FIFO of DEPTH entries, each holding {addr[ADDR_WIDTH-1:2], data}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- wrReady = (count != DEPTH); it is purely count-based, with no same-cycle pop-to-push bypass.
- Push: writes the entry at tail, tail+1, count+1.
- Drain FSM:
  - IDLE: if count>0, the next state is REQ. memAddress/memWriteData are registered from the head entry, memReq=1 from the next cycle. A store pushed into an empty buffer raises memReq one cycle after acceptance.
  - REQ: memReq, memAddress and memWriteData are held stable until memAck=1.
    - On memAck, pop the head (head+1, count-1) and drop memReq.
    - If count-1>0 after the pop, return to IDLE; no back-to-back requests, so there is a minimum 1-cycle gap with memReq low between writes.
- The in-flight entry stays counted (and visible to lookup) until acked.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - Push is legal only if count != DEPTH before the edge.
  - When full, a same-cycle pop does not admit a push.
- Lookup:
  - Compares against all valid entries, including the in-flight head.
  - The youngest entry (closest to tail) wins.
  - Purely combinational; does not consider a store being pushed in the same cycle.
- bufferEmpty is combinational from count and FSM state.

Optional Feature:
- Macro: WB_COALESCE_EN.
- When defined, a store whose word address matches a valid entry that is not the in-flight head overwrites that entry's data in place:
  - No push, count unchanged.
  - Accepted even when full (wrReady=1 if a coalescing match exists).
  - With multiple matches, the youngest is updated.
- When undefined, every accepted store allocates a new entry and duplicates are drained in order.

Test Plan:
- Reset then single store 0x0000_0010/0xDEAD_BEEF:
  - memReq rises 1 cycle after acceptance with memAddress=0x10, memWriteData=0xDEADBEEF.
  - Hold memAck=0 for 3 cycles -> outputs stable.
  - Ack -> memReq=0 next cycle; bufferEmpty=1.
- 5 stores back-to-back with memAck=0 (DEPTH=4):
  - wrReady=0 after the 4th; the 5th is stalled until the first ack.
  - Memory sees addresses in push order.
- Full buffer, push held while memAck pulses -> count stays 4 that cycle, and the 5th is accepted the cycle after.
- Stores 0x20/0x1111 then 0x20/0x2222 pending:
  - Lookup of 0x23 -> lookupHit=1, lookupData=0x2222.
  - Lookup of 0x24 -> lookupHit=0, lookupData=0.
- Assert reset_n low while memReq=1 -> memReq, count and bufferEmpty reset asynchronously; a late memAck causes no pop.
- WB_COALESCE_EN defined:
  - Stores 0x40/A, 0x44/B, 0x44/C -> 2 memory writes, and 0x44 is written with C.
  - Without the macro -> 3 writes.
